// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory port, redirect/halt from execute,
// and the decode-facing valid/ready instruction stream.
interface fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        halted;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect,
        input  redirect_pc,
        input  halt,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect,
        output redirect_pc,
        output halt,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready,
        input  halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: one outstanding fixed-latency imem read at a
// time, results queued in a small circular prefetch buffer toward decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          READ_LAT = 2,
    parameter int          DEPTH    = 2
) (
    input logic      clk,
    input logic      reset,
    fetch_if.master  fif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALTED} state_t;
    typedef logic [PW-1:0] ptr_t;

    state_t        state, state_next;
    logic [31:0]   pc;
    logic [31:0]   addr_q;
    logic [3:0]    lat_cnt;
    ptr_t          head, tail;
    logic [CW-1:0] count;
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];

    logic has_space, issue, capture, pop, valid;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // NOTE: every variable gets a default at the top of a combinational block,
    // so no path through it can leave a latch behind.
    always_comb begin
        state_next = state;
        if (fif.redirect) begin
            state_next = S_FETCH;
        end else begin
            unique case (state)
                S_FETCH:  if (fif.halt)          state_next = S_HALTED;
                          else if (has_space)    state_next = S_WAIT;
                S_WAIT:   if (lat_cnt == 4'd1)   state_next = fif.halt ? S_HALTED : S_FETCH;
                S_HALTED: if (!fif.halt)         state_next = S_FETCH;
                default:                         state_next = S_FETCH;
            endcase
        end
    end

    // Redirect abandons any in-flight read, so it masks both issue and capture.
    always_comb begin
        valid     = (count != '0);
        has_space = (count < CW'(DEPTH));
        issue     = 1'b0;
        capture   = 1'b0;
        if (!fif.redirect) begin
            issue   = (state == S_FETCH) && !fif.halt && has_space;
            capture = (state == S_WAIT) && (lat_cnt == 4'd1);
        end
        pop = valid && fif.instr_ready;
    end

    assign fif.imem_addr   = addr_q;
    assign fif.instr_valid = valid;
    assign fif.instr       = buf_instr[head];
    assign fif.instr_pc    = buf_pc[head];
    assign fif.halted      = (state == S_HALTED);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            addr_q  <= RESET_PC;
            lat_cnt <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            // NOTE: the buffer storage is reset because the head entry is
            // visible on instr/instr_pc and must read as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (fif.redirect) begin
            pc      <= fif.redirect_pc & ~32'd3;
            lat_cnt <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (issue) begin
                addr_q  <= pc;
                lat_cnt <= 4'(READ_LAT);
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            if (capture) begin
                buf_instr[tail] <= fif.imem_instr;
                buf_pc[tail]    <= addr_q;
                tail            <= ptr_inc(tail);
                pc              <= pc + 32'd4;
            end

            if (pop) head <= ptr_inc(head);

            unique case ({capture, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a transaction-level model (queue of
// fetched words, one outstanding read) predicts outputs after every edge.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam int          READ_LAT = 2;
    localparam int          DEPTH    = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic clk;
    logic reset;
    fetch_if fif ();

    fetch_sequencer #(
        .RESET_PC(RESET_PC),
        .READ_LAT(READ_LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .fif  (fif)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_pc, m_addr;
    bit          m_busy, m_halted;
    int          m_left;
    entry_t      m_q[$];

    // Memory latency model state
    logic [31:0] last_addr = 32'hFFFF_FFFF;
    int          age = 0;

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // GCD program at 0x00..0x30, hashed filler elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h58000001;
            32'h04:  return 32'h58080002;
            32'h08:  return 32'h8C020003;
            32'h0C:  return 32'h10430006;
            32'h10:  return 32'h0043202A;
            32'h14:  return 32'h14800002;
            32'h18:  return 32'h00621822;
            32'h1C:  return 32'h08000003;
            32'h20:  return 32'h00431022;
            32'h24:  return 32'h08000003;
            32'h28:  return 32'hAC020004;
            32'h2C:  return 32'h0000000C;
            32'h30:  return 32'h08000000;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit rd, input logic [31:0] rpc,
                              input bit h, input bit rdy);
        int sz0 = m_q.size();
        if (r) begin
            m_pc = RESET_PC; m_addr = RESET_PC;
            m_q.delete(); m_busy = 0; m_left = 0; m_halted = 0;
        end else if (rd) begin
            m_pc = rpc & ~32'd3;
            m_q.delete(); m_busy = 0; m_halted = 0;
        end else begin
            if (sz0 > 0 && rdy) void'(m_q.pop_front());
            if (m_halted) begin
                if (!h) m_halted = 0;
            end else if (m_busy) begin
                if (m_left == 1) begin
                    m_q.push_back('{instr: mem_word(m_addr), pc: m_addr});
                    m_pc     = m_pc + 32'd4;
                    m_busy   = 0;
                    m_halted = h;
                end else begin
                    m_left--;
                end
            end else if (h) begin
                m_halted = 1;
            end else if (sz0 < DEPTH) begin
                m_addr = m_pc;
                m_busy = 1;
                m_left = READ_LAT;
            end
        end
    endtask

    // Read data is only meaningful READ_LAT cycles after the address changes
    task automatic mem_update();
        if (fif.imem_addr !== last_addr) begin
            last_addr = fif.imem_addr;
            age = 0;
        end else if (age < 15) begin
            age++;
        end
        fif.imem_instr = (age >= READ_LAT - 1) ? mem_word(last_addr)
                                               : (32'hBAD00000 ^ last_addr);
    endtask

    task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                        input bit h, input bit rdy);
        reset           = r;
        fif.redirect    = rd;
        fif.redirect_pc = rpc;
        fif.halt        = h;
        fif.instr_ready = rdy;
        @(posedge clk);
        model_edge(r, rd, rpc, h, rdy);
        #1;
        mem_update();
        check("valid",     fif.instr_valid, m_q.size() > 0);
        check("halted",    fif.halted,      m_halted);
        check("imem_addr", fif.imem_addr,   m_addr);
        if (m_q.size() > 0) begin
            check("instr",    fif.instr,    m_q[0].instr);
            check("instr_pc", fif.instr_pc, m_q[0].pc);
        end
    endtask

    // Six edges after reset with ready high: timing of the first two words
    task automatic first_fetch_checks();
        for (int n = 1; n <= 6; n++) begin
            step(0, 0, 0, 0, 1);
            if (n == 2) check("first_not_yet", fif.instr_valid, 1'b0);
            if (n == 3) begin
                check("first_valid", fif.instr_valid, 1'b1);
                check("first_instr", fif.instr,       32'h58000001);
                check("first_pc",    fif.instr_pc,    32'h0);
            end
            if (n == 4) check("gap_valid", fif.instr_valid, 1'b0);
            if (n == 6) begin
                check("second_instr", fif.instr,    32'h58080002);
                check("second_pc",    fif.instr_pc, 32'h4);
            end
        end
    endtask

    task automatic wait_busy(input int need, input bit rdy);
        for (int i = 0; i < 40 && !(m_busy && m_q.size() == need); i++)
            step(0, 0, 0, 0, rdy);
        check("wait_busy_bound", m_busy && m_q.size() == need, 1'b1);
    endtask

    initial begin
        bit h_rand;
        clk             = 0;
        reset           = 1;
        fif.redirect    = 0;
        fif.redirect_pc = 0;
        fif.halt        = 0;
        fif.instr_ready = 1;
        fif.imem_instr  = 0;

        // Reset state
        step(1, 0, 0, 0, 1);
        check("rst_valid",  fif.instr_valid, 1'b0);
        check("rst_instr",  fif.instr,       32'h0);
        check("rst_pc",     fif.instr_pc,    32'h0);
        check("rst_halted", fif.halted,      1'b0);
        check("rst_addr",   fif.imem_addr,   RESET_PC);

        first_fetch_checks();

        // Backpressure: fill, single pop, refill
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);
        check("bp_full", fif.instr_valid, 1'b1);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);

        // Redirect mid-WAIT with an entry buffered and a same-cycle pop
        step(0, 1, 32'h08, 0, 0);
        wait_busy(1, 0);
        step(0, 1, 32'h20, 0, 1);
        check("redir_flush", fif.instr_valid, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        check("redir_pc", fif.instr_pc, 32'h20);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // Halt while fetching 0x0C
        step(0, 1, 32'h0C, 0, 1);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
        check("halt_halted", fif.halted,    1'b1);
        check("halt_pc",     fif.instr_pc,  32'h0C);
        check("halt_addr",   fif.imem_addr, 32'h0C);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("unhalt_addr", fif.imem_addr, 32'h10);

        // PC wrap
        step(0, 1, 32'hFFFF_FFFC, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
        check("wrap_head", fif.instr_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1);
        check("wrap_next", fif.instr_pc, 32'h0);

        // Reset mid-WAIT with one entry buffered
        step(0, 1, 32'h40, 0, 0);
        wait_busy(1, 0);
        step(1, 0, 0, 0, 1);
        check("rst2_valid", fif.instr_valid, 1'b0);
        check("rst2_instr", fif.instr,       32'h0);
        first_fetch_checks();

        // Randomized traffic
        h_rand = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, rd, rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(199) == 0);
            rd  = ($urandom_range(19) == 0);
            rdy = ($urandom_range(3) != 0);
            rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                           : $urandom;
            if ($urandom_range(7) == 0) h_rand = ~h_rand;
            step(r, rd, rpc, h_rand, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
